bus_demux_ctrl: RTL
===================

// Module: bus_demux_ctrl
// PURPOSE
//  Parametrised 8088-family bus demultiplexer and chip-select/wait-state controller.
//  Sits between the CPU's multiplexed AD/A bus and the MEMORY_IO devices.
//  Registers address and cycle type on ALE and decodes NUM_REGIONS programmable windows.
//  Inserts per-region wait states on READY and steers the data transceiver.
// PARAMETERS
//  ADDR_W       20             full bus address width
//  DATA_W       8              multiplexed low-byte width (AD)
//  NUM_REGIONS  4              number of decode windows / CS outputs
//  WAIT_W       4              width of wait-state count
//  REGION_BASE  {ADDR_W}x N    base address per region
//  REGION_MASK  {ADDR_W}x N    compare mask per region (1 = bit compared)
//  REGION_IO    N bits         1 = region matches I/O cycles (IOM=0), 0 = memory (IOM=1)
//  REGION_WAIT  {WAIT_W}x N    wait states inserted per region
// PORTS
//  CLK      in     1                  system clock
//  RESET    in     1                  synchronous, active-high reset
//  ALE      in     1                  address latch enable
//  IOM      in     1                  1 = memory cycle, 0 = I/O cycle
//  RD       in     1                  read strobe, active low
//  WR       in     1                  write strobe, active low
//  DTR      in     1                  1 = CPU transmits, 0 = CPU receives
//  DEN      in     1                  data enable, active low
//  A        in     ADDR_W-DATA_W      upper address lines
//  AD       inout  DATA_W             CPU multiplexed address/data
//  Data     inout  DATA_W             device-side data bus
//  Address  out    ADDR_W             latched address
//  CS       out    NUM_REGIONS        one-hot chip selects, active high
//  READY    out    1                  to CPU; low = insert wait state
//  bus_err  out    1                  one-cycle pulse on an unmapped access
// BEHAVIOUR
//  Reset values: Address=0, io_q=0, addr_valid=0, CS=0, READY=1, bus_err=0, FSM=IDLE.
//  Latch: at posedge CLK with ALE=1, Address<={A,AD}, io_q<=~IOM, addr_valid<=1.
//   - Latency: 1 cycle. Address holds while ALE=0.
//  Decode (combinational from registered state):
//   - hit[i] = addr_valid & ((Address^BASE[i])&MASK[i])==0 & (REGION_IO[i]==io_q).
//   - CS = lowest-index hit only; never more than one bit set.
//  Strobe start: strb=~RD|~WR; start = strb & ~strb_q, where strb_q is registered.
//  FSM IDLE/WAIT/DONE:
//   - IDLE, start, hit, REGION_WAIT>0: cnt<=WAIT-1, READY<=0, go to WAIT.
//   - IDLE, start, hit, REGION_WAIT=0: READY stays 1, go to DONE.
//   - IDLE, start, no hit: bus_err=1 for one cycle, READY stays 1, go to DONE.
//   - WAIT: if cnt==0, READY<=1 and go to DONE; else cnt--.
//   - DONE: when strb=0, go to IDLE.
//   - Strobe released while in WAIT (abort): go to IDLE, READY<=1 next cycle.
//  Simultaneous ALE and start: decode uses the pre-capture Address; the new capture takes effect next cycle.
//  RESET mid-cycle: FSM returns to IDLE immediately and READY=1 on the next edge.
//  Transceiver (combinational):
//   - Data = (DTR & ~DEN) ? AD : 'z.
//   - AD = (~DTR & ~DEN & |CS & ~RESET) ? Data : 'z.
//   - Unmapped reads leave AD floating.
// STRUCTURE
//  Package bus_pkg:
//   - typedef enum {IDLE,WAIT,DONE} ws_state_t.
//   - typedef struct {base, mask, io, wait} region_t.
//   - Function region_hit().
//  Sub-module wait_state_gen: FSM + counter.
//   - Inputs: CLK, RESET, start, strb, hit, wait_n.
//   - Outputs: READY, bus_err.
//  Top level: latch, decoder loop, and transceiver assigns.
// TESTING
//  Defaults: regions 0 = mem 0x80000/0x80000/wait 2, 1 = mem 0x00000/0x80000/wait 0,
//  2 = IO 0x0FF00/0x0FFF0/wait 1, 3 = IO 0x01C00/0x0FE00/wait 3.
//  1. Reset for 5 cycles -> READY=1, CS=0, Address=0, AD/Data = 'z.
//  2. ALE with A,AD = 0x8_1234, IOM=1, then RD low -> CS=0001, READY low for exactly 2 cycles, read data appears on AD.
//  3. ALE 0x0_0010 with IOM=1, then WR low -> CS=0010, READY never low, AD value driven onto Data.
//  4. ALE 0x0FF05 with IOM=0 -> CS=0100 (not region 3); RD -> 1 wait state.
//  5. I/O access to 0x0_5000 -> CS=0, bus_err pulses once, READY=1, AD stays 'z.
//  6. Region 3 read, RD released after 1 wait cycle -> READY=1 next cycle, FSM back in IDLE.
//     Then RESET during WAIT -> READY=1 next edge.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and decode helper for the 8088-family bus demultiplexer.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 20;
  localparam int unsigned BUS_WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } ws_state_t;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] base;
    logic [BUS_ADDR_W-1:0] mask;
    logic                  io;
    logic [BUS_WAIT_W-1:0] wait_n;
  } region_t;

  // A region hits when the masked address bits match and the cycle type agrees.
  function automatic logic region_hit(input region_t r,
                                      input logic [BUS_ADDR_W-1:0] addr,
                                      input logic io_cyc,
                                      input logic valid);
    return valid && (((addr ^ r.base) & r.mask) == '0) && (r.io == io_cyc);
  endfunction

endpackage

// File: rtl/wait_state_gen.sv
// Wait-state FSM: holds READY low for the selected region's wait count,
// flags unmapped accesses, and tracks the strobe back to idle.
module wait_state_gen
  import bus_pkg::*;
#(
  parameter int unsigned WAIT_W = BUS_WAIT_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              strb,
  input  logic              hit,
  input  logic [WAIT_W-1:0] wait_n,
  output logic              READY,
  output logic              bus_err
);

  ws_state_t         state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              ready_d;
  logic              bus_err_d;

  // State, counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      READY   <= 1'b1;
      bus_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      READY   <= ready_d;
      bus_err <= bus_err_d;
    end
  end

  // Next-state and next-output logic; a strobe release in WAIT aborts the cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = READY;
    bus_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!hit) begin
            bus_err_d = 1'b1;
            state_d   = DONE;
          end else if (wait_n != '0) begin
            cnt_d   = wait_n - WAIT_W'(1);
            ready_d = 1'b0;
            state_d = WAIT;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT: begin
        if (!strb) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      DONE: begin
        if (!strb) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bus_demux_ctrl.sv
// 8088-family bus demultiplexer: address latch, region decode to one-hot
// chip selects, wait-state control and data transceiver steering.
module bus_demux_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = BUS_ADDR_W,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_REGIONS = 4,
  parameter int unsigned WAIT_W      = BUS_WAIT_W,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE =
    {20'h01C00, 20'h0FF00, 20'h00000, 20'h80000},
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_MASK =
    {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000},
  parameter logic [NUM_REGIONS-1:0] REGION_IO = 4'b1100,
  parameter logic [NUM_REGIONS-1:0][WAIT_W-1:0] REGION_WAIT =
    {4'd3, 4'd1, 4'd0, 4'd2}
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ALE,
  input  logic                     IOM,
  input  logic                     RD,
  input  logic                     WR,
  input  logic                     DTR,
  input  logic                     DEN,
  input  logic [ADDR_W-DATA_W-1:0] A,
  inout  wire  [DATA_W-1:0]        AD,
  inout  wire  [DATA_W-1:0]        Data,
  output logic [ADDR_W-1:0]        Address,
  output logic [NUM_REGIONS-1:0]   CS,
  output logic                     READY,
  output logic                     bus_err
);

  logic                              io_q;
  logic                              addr_valid;
  logic                              strb;
  logic                              strb_q;
  logic                              start;
  logic [NUM_REGIONS-1:0]            hit_vec;
  logic [NUM_REGIONS-1:0][WAIT_W-1:0] wait_vec;
  logic [NUM_REGIONS-1:0]            cs_c;
  logic                              hit_any;
  logic [WAIT_W-1:0]                 wait_sel;

  // Capture the demultiplexed address and cycle type on ALE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Address    <= '0;
      io_q       <= 1'b0;
      addr_valid <= 1'b0;
    end else if (ALE) begin
      Address    <= {A, AD};
      io_q       <= ~IOM;
      addr_valid <= 1'b1;
    end
  end

  assign strb  = ~RD | ~WR;
  assign start = strb & ~strb_q;

  // Previous strobe level for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) strb_q <= 1'b0;
    else       strb_q <= strb;
  end

  // Per-region window compare against the registered address.
  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    localparam region_t R = '{
      base:   BUS_ADDR_W'(REGION_BASE[g]),
      mask:   BUS_ADDR_W'(REGION_MASK[g]),
      io:     REGION_IO[g],
      wait_n: BUS_WAIT_W'(REGION_WAIT[g])
    };
    assign hit_vec[g]  = region_hit(R, BUS_ADDR_W'(Address), io_q, addr_valid);
    assign wait_vec[g] = WAIT_W'(R.wait_n);
  end

  // Lowest-index hit wins so at most one chip select is ever active.
  always_comb begin
    cs_c     = '0;
    hit_any  = 1'b0;
    wait_sel = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (hit_vec[i] && !hit_any) begin
        cs_c[i]  = 1'b1;
        hit_any  = 1'b1;
        wait_sel = wait_vec[i];
      end
    end
  end

  assign CS = cs_c;

  wait_state_gen #(
    .WAIT_W (WAIT_W)
  ) u_wait (
    .CLK     (CLK),
    .RESET   (RESET),
    .start   (start),
    .strb    (strb),
    .hit     (hit_any),
    .wait_n  (wait_sel),
    .READY   (READY),
    .bus_err (bus_err)
  );

  // Transceiver: writes pass CPU data out; reads return device data only when mapped.
  assign Data = (DTR && !DEN) ? AD : 'z;
  assign AD   = (!DTR && !DEN && (|CS) && !RESET) ? Data : 'z;

endmodule
